// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file write-port scheduler.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;
  typedef logic [1:0]        rf_cnt_t;

  localparam rf_cnt_t CNT_MAX = 2'd3;
endpackage

// File: rtl/regfile_wr_sched_if.sv
// Writeback requester bus: packed per-requester valid/ready/addr/data.
interface regfile_wr_sched_if #(
  parameter int NUM_REQ = 3
) ();
  import regfile_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin
    int         pos;
    logic [PTR_W-1:0] idx;
    logic       hit;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    pos         = 0;
    idx         = '0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos         = int'(ptr_i) + k;
      pos         = (pos >= NUM_REQ) ? (pos - NUM_REQ) : pos;
      idx         = PTR_W'(pos);
      hit         = !gnt_valid_o && req_i[idx];
      gnt_o[idx]  = hit;
      gnt_idx_o   = hit ? idx : gnt_idx_o;
      gnt_valid_o = gnt_valid_o | hit;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Round-robin write-port scheduler with per-register pending-write scoreboard.
// Optional feature macro: REGFILE_WR_SCHED_FWD_EN (in-flight write forwarding).
module regfile_wr_sched import regfile_pkg::*; #(
  parameter int NUM_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wr_sched_if.slave        req_if,
  input  logic                     wr_hold,
  input  logic                     rsv_valid,
  input  rf_addr_t                 rsv_addr,
  output logic                     rsv_ready,
  input  logic                     rd_en_1,
  input  logic                     rd_en_2,
  input  rf_addr_t                 rd_addr_1,
  input  rf_addr_t                 rd_addr_2,
  output logic                     stall_o,
  output logic                     rf_regwrite_ctrl,
  output rf_addr_t                 rf_write_register,
  output rf_data_t                 rf_write_data,
  output logic                     err_underflow
`ifdef REGFILE_WR_SCHED_FWD_EN
  ,
  output logic                     fwd_hit_1,
  output logic                     fwd_hit_2,
  output rf_data_t                 fwd_data_1,
  output rf_data_t                 fwd_data_2
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_elig_s, gnt_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_valid_s;
  logic               wr_q, wr_d;
  rf_addr_t           waddr_q, waddr_d;
  rf_data_t           wdata_q, wdata_d;
  logic               err_q, err_d;
  rf_cnt_t            cnt_q [NUM_REGS];
  rf_cnt_t            cnt_d [NUM_REGS];
  logic               rsv_fire_s, uflow_s, stall_1_s, stall_2_s;

  assign req_elig_s = req_if.req_valid & {NUM_REQ{~wr_hold}};

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i       (req_elig_s),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  assign req_if.req_ready = gnt_s;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_d     = gnt_valid_s;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (gnt_valid_s) begin
      rr_ptr_d = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (gnt_idx_s + PTR_W'(1));
      waddr_d  = req_if.req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
      wdata_d  = req_if.req_data[gnt_idx_s*DATA_W +: DATA_W];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  assign rsv_ready  = (cnt_q[rsv_addr] != CNT_MAX);
  assign rsv_fire_s = rsv_valid & rsv_ready;
  // A completing write against an empty count is a scheduling error, not a wrap.
  assign uflow_s    = wr_q & (cnt_q[waddr_q] == 2'd0);
  assign err_d      = err_q | uflow_s;

  always_comb begin
    logic inc_v, dec_v;
    inc_v = 1'b0;
    dec_v = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_v = rsv_fire_s && (rsv_addr == rf_addr_t'(r));
      dec_v = wr_q && (waddr_q == rf_addr_t'(r));
      case ({inc_v, dec_v})
        2'b10:   cnt_d[r] = cnt_q[r] + 2'd1;
        2'b01:   cnt_d[r] = (cnt_q[r] == 2'd0) ? 2'd0 : (cnt_q[r] - 2'd1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= 2'd0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef REGFILE_WR_SCHED_FWD_EN
  // Only the last outstanding write may be forwarded; older ones still stall.
  assign fwd_hit_1  = rd_en_1 & wr_q & (waddr_q == rd_addr_1) & (cnt_q[rd_addr_1] == 2'd1);
  assign fwd_hit_2  = rd_en_2 & wr_q & (waddr_q == rd_addr_2) & (cnt_q[rd_addr_2] == 2'd1);
  assign fwd_data_1 = wdata_q;
  assign fwd_data_2 = wdata_q;
  assign stall_1_s  = rd_en_1 & (cnt_q[rd_addr_1] != 2'd0) & ~fwd_hit_1;
  assign stall_2_s  = rd_en_2 & (cnt_q[rd_addr_2] != 2'd0) & ~fwd_hit_2;
`else
  assign stall_1_s  = rd_en_1 & (cnt_q[rd_addr_1] != 2'd0);
  assign stall_2_s  = rd_en_2 & (cnt_q[rd_addr_2] != 2'd0);
`endif

  assign stall_o           = stall_1_s | stall_2_s;
  assign rf_regwrite_ctrl  = wr_q;
  assign rf_write_register = waddr_q;
  assign rf_write_data     = wdata_q;
  assign err_underflow     = err_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a write scoreboard and a small reference model.
module tb_regfile_wr_sched;
  import regfile_pkg::*;

  localparam int NR = 3;

  typedef struct packed {
    rf_addr_t a;
    rf_data_t d;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst, wr_hold, rsv_valid, rsv_ready;
  rf_addr_t rsv_addr, rd_addr_1, rd_addr_2, rf_write_register;
  logic     rd_en_1, rd_en_2, stall_o, rf_regwrite_ctrl, err_underflow;
  rf_data_t rf_write_data;
`ifdef REGFILE_WR_SCHED_FWD_EN
  logic     fwd_hit_1, fwd_hit_2;
  rf_data_t fwd_data_1, fwd_data_2;
`endif

  int       n_assert = 0;
  int       n_fail   = 0;

  rf_cnt_t  m_cnt [NUM_REGS];
  int       m_ptr;
  logic     m_wr_v, m_err;
  rf_addr_t m_wr_addr;
  rf_data_t m_wr_data;
  exp_t     exp_q [$];

  regfile_wr_sched_if #(.NUM_REQ(NR)) bus ();

  regfile_wr_sched #(.NUM_REQ(NR)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_if            (bus),
    .wr_hold           (wr_hold),
    .rsv_valid         (rsv_valid),
    .rsv_addr          (rsv_addr),
    .rsv_ready         (rsv_ready),
    .rd_en_1           (rd_en_1),
    .rd_en_2           (rd_en_2),
    .rd_addr_1         (rd_addr_1),
    .rd_addr_2         (rd_addr_2),
    .stall_o           (stall_o),
    .rf_regwrite_ctrl  (rf_regwrite_ctrl),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .err_underflow     (err_underflow)
`ifdef REGFILE_WR_SCHED_FWD_EN
    ,
    .fwd_hit_1         (fwd_hit_1),
    .fwd_hit_2         (fwd_hit_2),
    .fwd_data_1        (fwd_data_1),
    .fwd_data_2        (fwd_data_2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input rf_addr_t a, input rf_data_t d);
    bus.req_valid[i]              = v;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic m_reset();
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 2'd0;
    m_ptr     = 0;
    m_wr_v    = 1'b0;
    m_err     = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
    exp_q.delete();
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic [NR-1:0] egnt;
    int            gi;
    logic          f1, f2, s1, s2, inc;
    exp_t          e;
    #1;
    egnt = '0;
    gi   = -1;
    if (!wr_hold) begin
      for (int k = 0; k < NR; k++) begin
        if (gi < 0 && bus.req_valid[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
      end
    end
    if (gi >= 0) egnt[gi] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(egnt));
    chk("rsv_ready", 32'(rsv_ready), 32'(m_cnt[rsv_addr] != 2'd3));
    f1 = 1'b0;
    f2 = 1'b0;
`ifdef REGFILE_WR_SCHED_FWD_EN
    f1 = rd_en_1 && m_wr_v && (m_wr_addr == rd_addr_1) && (m_cnt[rd_addr_1] == 2'd1);
    f2 = rd_en_2 && m_wr_v && (m_wr_addr == rd_addr_2) && (m_cnt[rd_addr_2] == 2'd1);
    chk("fwd_hit_1", 32'(fwd_hit_1), 32'(f1));
    chk("fwd_hit_2", 32'(fwd_hit_2), 32'(f2));
    if (f1) chk("fwd_data_1", fwd_data_1, m_wr_data);
    if (f2) chk("fwd_data_2", fwd_data_2, m_wr_data);
`endif
    s1 = rd_en_1 && (m_cnt[rd_addr_1] != 2'd0) && !f1;
    s2 = rd_en_2 && (m_cnt[rd_addr_2] != 2'd0) && !f2;
    chk("stall_o", 32'(stall_o), 32'(s1 | s2));

    inc = rsv_valid && (m_cnt[rsv_addr] != 2'd3);
    if (m_wr_v && m_cnt[m_wr_addr] == 2'd0) m_err = 1'b1;
    if (!(inc && m_wr_v && rsv_addr == m_wr_addr)) begin
      if (inc) m_cnt[rsv_addr] = m_cnt[rsv_addr] + 2'd1;
      if (m_wr_v && m_cnt[m_wr_addr] != 2'd0) m_cnt[m_wr_addr] = m_cnt[m_wr_addr] - 2'd1;
    end
    m_wr_v = (gi >= 0);
    if (gi >= 0) begin
      m_wr_addr = bus.req_addr[gi*ADDR_W +: ADDR_W];
      m_wr_data = bus.req_data[gi*DATA_W +: DATA_W];
      exp_q.push_back({m_wr_addr, m_wr_data});
      m_ptr = (gi + 1) % NR;
    end

    @(posedge clk);
    #1;
    chk("rf_regwrite_ctrl", 32'(rf_regwrite_ctrl), 32'(m_wr_v));
    chk("rf_write_register", 32'(rf_write_register), 32'(m_wr_addr));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
    if (rf_regwrite_ctrl === 1'b1) begin
      chk("sb_depth", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(rf_write_register), 32'(e.a));
        chk("sb_data", rf_write_data, e.d);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_hold = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    rd_en_1 = 1'b0; rd_en_2 = 1'b0; rd_addr_1 = '0; rd_addr_2 = '0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsv_ready", 32'(rsv_ready), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wr", 32'(rf_regwrite_ctrl), 32'd0);
    chk("rst_waddr", 32'(rf_write_register), 32'd0);
    chk("rst_wdata", rf_write_data, 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    rst = 1'b0;

    // Reserve r7, then read it.
    rsv_valid = 1'b1; rsv_addr = 5'd7; step();
    rsv_valid = 1'b0; rd_en_1 = 1'b1; rd_addr_1 = 5'd7; step();
    chk("stall_r7", 32'(stall_o), 32'd1);
    rd_en_1 = 1'b0;

    // Reserve r20..r22 twice each, then a held cycle and a 6-cycle burst.
    rsv_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rsv_addr = rf_addr_t'(20 + (k % 3));
      step();
    end
    rsv_valid = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, rf_addr_t'(20 + i), 32'hA000_0000 + i);
    wr_hold = 1'b1; step();
    wr_hold = 1'b0;
    repeat (6) step();
    bus.req_valid = '0; step(); step();

    // r5: two reservations, two writes.
    rsv_valid = 1'b1; rsv_addr = 5'd5; step(); step();
    rsv_valid = 1'b0; rd_en_1 = 1'b1; rd_addr_1 = 5'd5;
    set_req(1, 1'b1, 5'd5, 32'h5555_0001); step();
    bus.req_valid = '0; step(); step();
    chk("stall_r5_persist", 32'(stall_o), 32'd1);
    set_req(2, 1'b1, 5'd5, 32'h5555_0002); step();
    bus.req_valid = '0; step(); step();
    chk("stall_r5_clear", 32'(stall_o), 32'd0);
    rd_en_1 = 1'b0;

    // r9: reservation coincides with write completion.
    rsv_valid = 1'b1; rsv_addr = 5'd9; step();
    rsv_valid = 1'b0; rd_en_2 = 1'b1; rd_addr_2 = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h9999_0009); step();
    bus.req_valid = '0; rsv_valid = 1'b1; rsv_addr = 5'd9; step();
    rsv_valid = 1'b0; step();
    chk("stall_r9_cnt1", 32'(stall_o), 32'd1);
    rd_en_2 = 1'b0;

    // r3 underflow, then asynchronous reset mid-burst.
    set_req(1, 1'b1, 5'd3, 32'h3333_3333); step();
    bus.req_valid = '0; step(); step();
    chk("err_sticky", 32'(err_underflow), 32'd1);
    repeat (3) step();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, rf_addr_t'(20 + i), 32'hB000_0000 + i);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_wr", 32'(rf_regwrite_ctrl), 32'd0);
    chk("rst_async_err", 32'(err_underflow), 32'd0);
    m_reset();
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // r12 read while its write is in flight.
    rsv_valid = 1'b1; rsv_addr = 5'd12; step();
    rsv_valid = 1'b0; rd_en_1 = 1'b1; rd_addr_1 = 5'd12;
    set_req(1, 1'b1, 5'd12, 32'hDEAD_BEEF); step();
    bus.req_valid = '0;
    #1;
`ifdef REGFILE_WR_SCHED_FWD_EN
    chk("fwd_r12_hit", 32'(fwd_hit_1), 32'd1);
    chk("fwd_r12_data", fwd_data_1, 32'hDEAD_BEEF);
    chk("fwd_r12_stall", 32'(stall_o), 32'd0);
`else
    chk("nofwd_r12_stall", 32'(stall_o), 32'd1);
`endif
    step(); step();
    rd_en_1 = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler and hazard scoreboard for the 32x32 register file. Shares the file's single write port (write_register / write_data / regwrite_ctrl) between NUM_REQ writeback requesters using round-robin arbitration. Tracks outstanding reservations per register and raises a read-hazard stall to the decode stage. Sits between the writeback sources (ALU, load unit, debug) and the register file.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..4)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i holds a write
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid & ready
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing
- wr_hold  in  1  when high, no grants are issued
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  ADDR_W  register being reserved
- rsv_ready  out  1  reservation accepted; low when that register's count is 3
- rd_en_1, rd_en_2  in  1 each  operand read enables
- rd_addr_1, rd_addr_2  in  ADDR_W each  operand addresses
- stall_o  out  1  a read operand has an outstanding write
- rf_regwrite_ctrl  out  1  write strobe to the register file (registered)
- rf_write_register  out  ADDR_W  registered write address
- rf_write_data  out  DATA_W  registered write data
- err_underflow  out  1  sticky; a write hit a register whose count was 0

## Operation
- Arbitration: round-robin starting at pointer rr_ptr. Grant goes to the first valid requester at or after rr_ptr. At most one grant per cycle; zero grants when wr_hold=1.
- After a grant to i, rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr holds when there is no grant.
- req_ready is combinational from req_valid, rr_ptr and wr_hold. The output stage never back-pressures.
- Output stage: on a grant, the next cycle drives rf_regwrite_ctrl=1 with the granted addr/data. Otherwise rf_regwrite_ctrl=0 and addr/data hold their last values.
- Address 0 is an ordinary writable register: no suppression.
- Scoreboard: a 2-bit pending count per register.
  - Increment on rsv_valid & rsv_ready for rsv_addr.
  - Decrement on a cycle where rf_regwrite_ctrl=1, for rf_write_register.
  - Increment and decrement of the same register in the same cycle leave the count unchanged.
  - Decrement at count 0: count stays 0 and err_underflow is set.
- stall_o = (rd_en_1 & count[rd_addr_1]!=0) | (rd_en_2 & count[rd_addr_2]!=0).

## Timing
- Reset values: req_ready=0, rsv_ready=1, stall_o=0, rf_regwrite_ctrl=0, rf_write_register=0, rf_write_data=0, err_underflow=0. All counts are 0 and rr_ptr=0.
- Latency: a handshake in cycle N produces rf_regwrite_ctrl=1 in cycle N+1. The register file captures the write in N+1. The count decrement becomes visible in N+2.
- Reservation in cycle N: the count is visible in N+1, and stall_o can assert in N+1.
- Back-to-back grants every cycle are allowed, giving a sustained throughput of 1 write/cycle.
- Reset asserted mid-operation clears everything asynchronously and drops any in-flight write. err_underflow is cleared only by rst.

## Configuration
- REGFILE_WR_SCHED_FWD_EN defined: read-operand forwarding is enabled. A read operand that matches rf_write_register while rf_regwrite_ctrl=1 and whose count==1 does not stall. In that case fwd_hit_1/fwd_hit_2 (out, 1) assert and fwd_data_1/fwd_data_2 (out, DATA_W) carry rf_write_data.
- Undefined: those four ports are absent and stall_o ignores in-flight writes.

## Structure
- Shared package regfile_pkg provides DATA_W, ADDR_W, NUM_REGS=32, typedefs rf_addr_t, rf_data_t and rf_cnt_t (2-bit).
- One sub-module, rr_arbiter, takes NUM_REQ, req vector and ptr, and produces a one-hot grant and grant index. It is purely combinational.
- Scoreboard and output register live in regfile_wr_sched.

## Test plan
- Reset then idle: all outputs at their reset values. Driving rsv_valid with addr 7 gives count[7]=1 and stall_o=1 when rd_addr_1=7 with rd_en_1=1.
- All three requesters valid for 6 cycles: grants go 0,1,2,0,1,2, and rf_regwrite_ctrl is high for 6 consecutive cycles starting one cycle after the first grant.
- Reserve r5 twice, then write r5 once: count goes 2→1 and stall persists. A second write clears the stall in the cycle after its rf_regwrite_ctrl.
- Same-cycle reservation and write-completion on r9 with count 1: count stays 1.
- Write to r3 with count 0: the write is performed, err_underflow=1 and stays high until rst. Asserting rst mid-burst gives rf_regwrite_ctrl=0 immediately.
- With REGFILE_WR_SCHED_FWD_EN defined: reserve r12, write 0xDEADBEEF, read r12 during the rf_regwrite_ctrl cycle. Expected: fwd_hit_1=1, fwd_data_1=0xDEADBEEF, stall_o=0.
